riscv_alu_issue: RTL and testbench

Issue/sequencing front end for the core's ALU. It accepts one decoded-stage instruction word plus register operands over a valid/ready handshake. It extracts the OP/OP-IMM fields and holds the ALU request stable for as long as the ALU reports `is_alu_wait`, which covers multicycle mul/div. It then captures the result and presents it to register-file writeback over a second valid/ready handshake.

---
 rtl/riscv_alu_issue.sv | 149 ++++++++++++++
 tb/tb_riscv_alu_issue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_issue.sv
// Purpose : ALU issue/sequencing front end: decodes OP/OP-IMM, holds the ALU request through alu_wait, hands result to writeback.
// Latency : single-cycle op accepted at edge T is in EXEC during T+1 and presents wb_valid from T+2; multicycle adds one cycle per alu_wait cycle.
// Backpres: in_ready low in EXEC and WB; WB holds result stable indefinitely until wb_ready.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       - instruction handshake; in_instr, in_rs1_val, in_rs2_val payload
//   alu_*  (out)            - ALU request, non-zero only in EXEC and held constant there
//   alu_rd, alu_wait (in)   - ALU result and busy flag
//   wb_valid/wb_ready       - writeback handshake; wb_rd_addr, wb_data payload
//   illegal                 - one-cycle pulse after accepting a non-ALU opcode
//
// Build option: define ALU_ISSUE_BACK_TO_BACK_EN to also accept a new instruction in the
// cycle WB hands off its result (1 single-cycle op per 2 cycles instead of per 3).

module riscv_alu_issue (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        alu_is_op,
  output logic        alu_is_op_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_imm,
  input  logic [31:0] alu_rd,
  input  logic        alu_wait,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        op_q, op_imm_q;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [4:0]  rd_q;
  logic [31:0] rs1_q, rs2_q, imm_q;
  logic [31:0] result_q;
  logic        illegal_q;

  logic dec_op, dec_op_imm, dec_legal;
  logic accept;
  logic capture;

  // rs1 register-address bits are not needed here: operands arrive by value.
  logic unused_rs1_addr;
  assign unused_rs1_addr = ^in_instr[19:15];

  assign dec_op     = (in_instr[6:0] == OPC_OP);
  assign dec_op_imm = (in_instr[6:0] == OPC_OP_IMM);
  assign dec_legal  = dec_op | dec_op_imm;

  // in_ready is gated by the reset net so it reads 0 for the whole time reset is held.
`ifdef ALU_ISSUE_BACK_TO_BACK_EN
  assign in_ready = reset & ((state_q == S_IDLE) | ((state_q == S_WB) & wb_ready));
`else
  assign in_ready = reset & (state_q == S_IDLE);
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && dec_legal) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!alu_wait) begin
          capture = 1'b1;
          // Writes to x0 are architecturally discarded, so skip the WB handshake.
          state_d = (rd_q != 5'd0) ? S_WB : S_IDLE;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = (accept && dec_legal) ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      op_imm_q  <= 1'b0;
      funct3_q  <= 3'd0;
      funct7_q  <= 7'd0;
      rd_q      <= 5'd0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      imm_q     <= 32'd0;
      result_q  <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept & ~dec_legal;
      if (accept) begin
        op_q     <= dec_op;
        op_imm_q <= dec_op_imm;
        funct3_q <= in_instr[14:12];
        funct7_q <= in_instr[31:25];
        rd_q     <= in_instr[11:7];
        rs1_q    <= in_rs1_val;
        rs2_q    <= in_rs2_val;
        imm_q    <= {{20{in_instr[31]}}, in_instr[31:20]};
      end
      if (capture) result_q <= alu_rd;
    end
  end

  // The ALU releases its mul/div engine when the request drops, so every alu_* output
  // is forced to zero outside EXEC rather than left showing the latched values.
  logic in_exec;
  assign in_exec = (state_q == S_EXEC);

  assign alu_is_op     = in_exec & op_q;
  assign alu_is_op_imm = in_exec & op_imm_q;
  assign alu_funct3    = in_exec ? funct3_q : 3'd0;
  assign alu_funct7    = in_exec ? funct7_q : 7'd0;
  assign alu_rs1       = in_exec ? rs1_q    : 32'd0;
  assign alu_rs2       = in_exec ? rs2_q    : 32'd0;
  assign alu_imm       = in_exec ? imm_q    : 32'd0;

  assign wb_valid   = (state_q == S_WB);
  assign wb_data    = wb_valid ? result_q : 32'd0;
  assign wb_rd_addr = wb_valid ? rd_q     : 5'd0;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_riscv_alu_issue.sv
module tb_riscv_alu_issue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic        alu_is_op, alu_is_op_imm;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_rs1, alu_rs2, alu_imm;
  logic [31:0] alu_rd;
  logic        alu_wait;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        illegal;

  always #5 clock = ~clock;

  riscv_alu_issue dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_is_op(alu_is_op), .alu_is_op_imm(alu_is_op_imm),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
    .alu_rd(alu_rd), .alu_wait(alu_wait),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .illegal(illegal)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Architectural RV32I/M ALU semantics.
  function automatic logic [31:0] alu_calc(input logic is_imm, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    logic signed [63:0] sp;
    if (!is_imm && f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
        3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
        3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFF_FFFF;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
          return $signed(a) / $signed(b);
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return $signed(a) % $signed(b);
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
    case (f3)
      3'd0: return (!is_imm && f7[5]) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, $signed(a) < $signed(b)};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: begin
        if (f7[5]) return $signed(a) >>> b[4:0];
        return a >> b[4:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Stand-in ALU: mul/div with both operands non-zero is busy for mc_lat cycles.
  int unsigned mc_lat = 2;
  int unsigned wcnt;
  logic alu_req, alu_mc;
  assign alu_req  = alu_is_op | alu_is_op_imm;
  assign alu_mc   = alu_is_op && alu_funct7 == 7'h01 && alu_rs1 != 0 && alu_rs2 != 0;
  assign alu_wait = alu_req && alu_mc && (wcnt < mc_lat);
  always_comb begin
    alu_rd = 32'hDEAD_BEEF;
    if (!alu_wait)
      alu_rd = alu_calc(alu_is_op_imm, alu_funct3, alu_funct7, alu_rs1,
                        alu_is_op_imm ? alu_imm : alu_rs2);
  end
  always @(posedge clock or negedge reset) begin
    if (!reset) wcnt <= 0;
    else if (alu_wait) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  int n_xfer = 0;
  int n_illegal = 0;
  always @(posedge clock) begin
    if (wb_valid && wb_ready) n_xfer <= n_xfer + 1;
    if (illegal) n_illegal <= n_illegal + 1;
  end

  function automatic logic [127:0] alu_vec();
    return {20'b0, alu_is_op, alu_is_op_imm, alu_funct3, alu_funct7, alu_rs1, alu_rs2, alu_imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'h13};
  endfunction

`ifdef ALU_ISSUE_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  // Issue one instruction and follow it through to writeback (or its absence).
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int hold, input bit has_const, input logic [31:0] exp_const,
                       input string tag);
    logic        is_op, is_imm, legal;
    logic [4:0]  rd;
    logic [31:0] imm, exp_data;
    logic [127:0] exp_alu;
    int unsigned exp_n;
    int t, ec, x0, i0;
    is_op    = (instr[6:0] == 7'b0110011);
    is_imm   = (instr[6:0] == 7'b0010011);
    legal    = is_op | is_imm;
    rd       = instr[11:7];
    imm      = {{20{instr[31]}}, instr[31:20]};
    exp_data = alu_calc(is_imm, instr[14:12], instr[31:25], rs1, is_imm ? imm : rs2);
    exp_alu  = {20'b0, is_op, is_imm, instr[14:12], instr[31:25], rs1, rs2, imm};
    exp_n    = (is_op && instr[31:25] == 7'h01 && rs1 != 0 && rs2 != 0) ? mc_lat : 0;
    if (has_const) chk({tag, "_model"}, exp_data, exp_const);

    t = 0;
    while (!in_ready && t < 100) begin @(negedge clock); t++; end
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    wb_ready   = (hold == 0);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    x0 = n_xfer;
    i0 = n_illegal;
    @(negedge clock);
    in_valid   = 1'b0;
    in_instr   = $urandom;
    in_rs1_val = $urandom;
    in_rs2_val = $urandom;

    if (!legal) begin
      chk({tag, "_illegal_pulse"}, illegal, 1'b1);
      chk({tag, "_illegal_noalu"}, alu_vec(), 128'd0);
      chk({tag, "_illegal_rdy"}, in_ready, 1'b1);
      @(negedge clock);
      chk({tag, "_illegal_once"}, {illegal, 32'(n_illegal - i0)}, {1'b0, 32'd1});
      chk({tag, "_illegal_nowb"}, wb_valid, 1'b0);
      return;
    end

    ec = 0;
    while (ec < 50) begin
      chk({tag, "_alu_hold"}, alu_vec(), exp_alu);
      chk({tag, "_exec_rdy"}, in_ready, 1'b0);
      ec++;
      if (!alu_wait) break;
      @(negedge clock);
    end
    chk({tag, "_exec_cycles"}, ec, exp_n + 1);
    @(negedge clock);
    chk({tag, "_alu_release"}, {alu_is_op, alu_is_op_imm}, 2'b00);

    if (rd == 5'd0) begin
      chk({tag, "_x0_nowb"}, wb_valid, 1'b0);
      chk({tag, "_x0_rdy"}, in_ready, 1'b1);
      chk({tag, "_x0_noxfer"}, n_xfer - x0, 0);
      return;
    end

    chk({tag, "_wb_valid"}, wb_valid, 1'b1);
    chk({tag, "_wb_addr"}, wb_rd_addr, rd);
    chk({tag, "_wb_data"}, wb_data, exp_data);
    if (has_const) chk({tag, "_wb_const"}, wb_data, exp_const);
    chk({tag, "_wb_rdy"}, in_ready, B2B && hold == 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk({tag, "_hold"}, {in_ready, wb_valid, wb_rd_addr, wb_data}, {1'b0, 1'b1, rd, exp_data});
    end
    wb_ready = 1'b1;
    @(negedge clock);
    wb_ready = 1'b0;
    chk({tag, "_wb_done"}, {wb_valid, in_ready}, 2'b01);
    chk({tag, "_one_xfer"}, n_xfer - x0, 1);
  endtask

  logic [6:0] bad_ops [5] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};

  initial begin
    #500000;
    $display("FAIL timeout: observed time %0t required finish before 500000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_alu", alu_vec(), 128'd0);
    chk("reset_ctl", {in_ready, wb_valid, wb_rd_addr, wb_data, illegal}, '0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_rdy", {in_ready, wb_valid, illegal}, 3'b100);

    // Directed cases
    issue(r_type(7'h00, 3'd0, 5'd5), 32'd7, 32'd5, 0, 1, 32'd12, "add");
    issue(r_type(7'h20, 3'd0, 5'd5), 32'd7, 32'd5, 0, 1, 32'd2, "sub");
    issue(i_type(12'hFFF, 3'd0, 5'd3), 32'd1, 32'd9, 0, 1, 32'd0, "addi");
    mc_lat = 3;
    issue(r_type(7'h01, 3'd0, 5'd4), 32'd3, 32'h0001_0000, 0, 1, 32'h0003_0000, "mul");
    issue(r_type(7'h01, 3'd5, 5'd6), 32'd100, 32'd7, 1, 1, 32'd14, "divu");
    issue(r_type(7'h01, 3'd0, 5'd7), 32'd0, 32'd55, 0, 1, 32'd0, "mul_zero");
    issue(r_type(7'h00, 3'd0, 5'd0), 32'd1, 32'd2, 0, 0, 32'd0, "add_x0");
    issue({25'h0AB_CDEF, 7'b0000011}, 32'd4, 32'd4, 0, 0, 32'd0, "load_illegal");
    issue(r_type(7'h00, 3'd4, 5'd9), 32'hF0F0_1234, 32'h0FF0_4321, 5, 1, 32'hFF00_5115, "xor_hold5");

    // Reset while a multicycle op is in EXEC
    mc_lat = 4;
    wb_ready   = 1'b1;
    in_valid   = 1'b1;
    in_instr   = r_type(7'h01, 3'd0, 5'd8);
    in_rs1_val = 32'd6;
    in_rs2_val = 32'd7;
    @(negedge clock);
    in_valid = 1'b0;
    chk("rst_mid_in_exec", alu_is_op, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mid_alu", alu_vec(), 128'd0);
    chk("rst_mid_ctl", {in_ready, wb_valid, wb_rd_addr, wb_data, illegal}, '0);
    @(negedge clock);
    reset = 1'b1;
    begin
      int x0;
      x0 = n_xfer;
      repeat (6) begin
        @(negedge clock);
        chk("rst_mid_nowb", {wb_valid, in_ready, alu_is_op}, 3'b010);
      end
      chk("rst_mid_noxfer", n_xfer - x0, 0);
    end
    wb_ready = 1'b0;

`ifdef ALU_ISSUE_BACK_TO_BACK_EN
    // Two ADDs offered back to back: second accepted in the WB handoff cycle.
    begin
      int x0;
      x0 = n_xfer;
      wb_ready   = 1'b1;
      in_valid   = 1'b1;
      in_instr   = r_type(7'h00, 3'd0, 5'd10);
      in_rs1_val = 32'd1;
      in_rs2_val = 32'd2;
      @(negedge clock);
      chk("b2b_exec1", {wb_valid, in_ready}, 2'b00);
      in_instr   = r_type(7'h00, 3'd0, 5'd11);
      in_rs1_val = 32'd40;
      in_rs2_val = 32'd2;
      @(negedge clock);
      chk("b2b_wb1", {wb_valid, in_ready, wb_rd_addr, wb_data}, {2'b11, 5'd10, 32'd3});
      @(negedge clock);
      in_valid = 1'b0;
      chk("b2b_exec2", {wb_valid, alu_is_op}, 2'b01);
      @(negedge clock);
      chk("b2b_wb2", {wb_valid, wb_rd_addr, wb_data}, {1'b1, 5'd11, 32'd42});
      @(negedge clock);
      chk("b2b_xfers", n_xfer - x0, 2);
      wb_ready = 1'b0;
    end
`endif

    // Randomized instruction mix
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ins, a, b;
      logic [4:0]  rd;
      int kind;
      kind = $urandom_range(0, 9);
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      mc_lat = $urandom_range(1, 4);
      case (kind)
        0:       ins = {25'($urandom), bad_ops[$urandom_range(0, 4)]};
        1, 2, 3, 4: begin
          logic [2:0] f3;
          f3  = 3'($urandom);
          ins = r_type(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1)) ? 7'h20 : 7'h00, f3, rd);
        end
        5, 6, 7: ins = i_type(12'($urandom), 3'($urandom), rd);
        default: ins = r_type(7'h01, 3'($urandom), rd);
      endcase
      issue(ins, a, b, $urandom_range(0, 2), 0, 32'd0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
